kbd_event_fifo: RTL and testbench

Downstream consumer of the PS/2 keyboard driver's 8-bit SCANCODE and interrupt-pulse outputs. It edge-detects each interrupt pulse and decodes the E0 (extended) and F0 (break) prefix bytes. Each complete key event is packed as {ext, brk, code} and buffered in a first-word-fall-through FIFO. The OTTER MMIO bus pops events, and a level IRQ is raised toward the CPU while the FIFO holds data.

---
 rtl/kbd_event_fifo.sv | 121 ++++++++++++
 tb/tb_kbd_event_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_fifo.sv
// PS/2 key-event decoder and first-word-fall-through event FIFO.
// Folds E0/F0 prefixes into {ext, brk, code} entries and raises a level IRQ while the FIFO holds data.
module kbd_event_fifo #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          INTRPT_IN,
  input  logic [7:0]    SCANCODE_IN,
  input  logic          RD_EN,
  input  logic          CLR,
  output logic [9:0]    EVT_DATA,
  output logic          EVT_VALID,
  output logic [CW-1:0] COUNT,
  output logic          OVF,
  output logic          IRQ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  logic          intr_q_reg;
  logic          byte_tick;
  dec_state_t    dec_state_reg, dec_state_next;
  logic          push_req;
  logic [9:0]    push_data;
  logic          ext_bit, brk_bit;
  logic          is_err, is_e0, is_f0;

  logic [9:0]    mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          fifo_full, fifo_empty;
  logic          do_push, do_pop, drop_evt;

  // intr_q keeps tracking INTRPT_IN through CLR so a held pulse never re-triggers.
  always_ff @(posedge CLK) begin
    if (!RST_N) intr_q_reg <= 1'b0;
    else        intr_q_reg <= INTRPT_IN;
  end

  assign byte_tick = INTRPT_IN & ~intr_q_reg;

  assign is_err  = (SCANCODE_IN == 8'h00) || (SCANCODE_IN == 8'hFF);
  assign is_e0   = (SCANCODE_IN == 8'hE0);
  assign is_f0   = (SCANCODE_IN == 8'hF0);
  assign ext_bit = (dec_state_reg == EXT) || (dec_state_reg == EXT_BRK);
  assign brk_bit = (dec_state_reg == BRK) || (dec_state_reg == EXT_BRK);

  always_comb begin
    dec_state_next = dec_state_reg;
    push_req       = 1'b0;
    push_data      = {ext_bit, brk_bit, SCANCODE_IN};
    if (byte_tick) begin
      if (is_err) begin
        dec_state_next = IDLE;
      end else if (is_e0) begin
        dec_state_next = brk_bit ? EXT_BRK : EXT;
      end else if (is_f0) begin
        dec_state_next = ext_bit ? EXT_BRK : BRK;
      end else begin
        push_req       = 1'b1;
        dec_state_next = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) dec_state_reg <= IDLE;
    else               dec_state_reg <= dec_state_next;
  end

  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign do_pop     = RD_EN & ~fifo_empty & ~CLR;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push_req & (~fifo_full | do_pop) & ~CLR;
  assign drop_evt   = push_req & fifo_full & ~do_pop & ~CLR;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge CLK) begin
        if (do_push && (wr_ptr_reg == PW'(gi))) mem_reg[gi] <= push_data;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop_evt) ovf_reg <= 1'b1;
    end
  end

  assign EVT_DATA  = fifo_empty ? 10'd0 : mem_reg[rd_ptr_reg];
  assign EVT_VALID = ~fifo_empty;
  assign COUNT     = count_reg;
  assign OVF       = ovf_reg;
  assign IRQ       = ~fifo_empty;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Randomized and directed bench for kbd_event_fifo against a queue-based key-event model.
module tb_kbd_event_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          intrpt = 1'b0;
  logic [7:0]    scancode = 8'h00;
  logic          rd_en = 1'b0;
  logic          clr = 1'b0;
  logic [9:0]    evt_data;
  logic          evt_valid;
  logic [CW-1:0] count;
  logic          ovf;
  logic          irq;

  kbd_event_fifo #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_N(rst_n), .INTRPT_IN(intrpt), .SCANCODE_IN(scancode),
    .RD_EN(rd_en), .CLR(clr), .EVT_DATA(evt_data), .EVT_VALID(evt_valid),
    .COUNT(count), .OVF(ovf), .IRQ(irq)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: pending prefix flags plus a queue of packed events.
  logic       m_intr_q = 1'b0;
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic       m_ovf = 1'b0;
  logic [9:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else
      checks_passed++;
  endtask

  task automatic model_edge(input logic in_intr, input logic [7:0] sc, input logic rd,
                            input logic cl, input logic rn);
    logic tick, popping, was_full, want_push;
    logic [9:0] ev;
    if (!rn) begin
      m_intr_q = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_q.delete();
      return;
    end
    tick = in_intr && !m_intr_q;
    m_intr_q = in_intr;
    if (cl) begin
      m_q.delete(); m_ovf = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
      return;
    end
    want_push = 1'b0;
    ev = '0;
    if (tick) begin
      if (sc == 8'h00 || sc == 8'hFF) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else if (sc == 8'hE0) m_ext = 1'b1;
      else if (sc == 8'hF0) m_brk = 1'b1;
      else begin
        ev = {m_ext, m_brk, sc};
        want_push = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
    was_full = (m_q.size() == DEPTH);
    popping  = rd && (m_q.size() > 0);
    if (popping) void'(m_q.pop_front());
    if (want_push) begin
      if (was_full && !popping) m_ovf = 1'b1;
      else m_q.push_back(ev);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic in_intr, input logic [7:0] sc, input logic rd,
                      input logic cl, input logic rn);
    logic [9:0] head;
    intrpt = in_intr; scancode = sc; rd_en = rd; clr = cl; rst_n = rn;
    @(posedge clk);
    model_edge(in_intr, sc, rd, cl, rn);
    #1;
    head = (m_q.size() > 0) ? m_q[0] : 10'd0;
    check("COUNT", 32'(count), 32'(m_q.size()));
    check("EVT_DATA", 32'(evt_data), 32'(head));
    check("EVT_VALID", 32'(evt_valid), 32'(m_q.size() > 0));
    check("IRQ", 32'(irq), 32'(m_q.size() > 0));
    check("OVF", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic pulse(input logic [7:0] sc, input int len, input int gap);
    for (int i = 0; i < len; i++) step(1'b1, sc, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < gap; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop1();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_clr();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] sc;
    logic [7:0] pool[6];
    int len, gap;
    pool[0] = 8'h00; pool[1] = 8'hFF; pool[2] = 8'hE0;
    pool[3] = 8'hF0; pool[4] = 8'hE1; pool[5] = 8'h1C;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);

    // Single make code, then pop
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1);
    check("t1_data", 32'(evt_data), 32'h01C);
    check("t1_irq", 32'(irq), 32'd1);
    pulse(8'h1C, 6, 2);
    pop1();
    check("t1_pop_count", 32'(count), 32'd0);

    // Prefix decoding
    pulse(8'hE0, 7, 2);
    check("t2_prefix_count", 32'(count), 32'd0);
    pulse(8'h75, 7, 2);
    check("t2_ext", 32'(evt_data), 32'h275);
    pop1();
    pulse(8'hF0, 7, 2); pulse(8'h1C, 7, 2);
    check("t2_brk", 32'(evt_data), 32'h11C);
    pop1();
    pulse(8'hE0, 7, 2); pulse(8'hF0, 7, 2);
    check("t2_prefix2_count", 32'(count), 32'd0);
    pulse(8'h75, 7, 2);
    check("t2_extbrk", 32'(evt_data), 32'h375);
    pop1();

    // Error codes drop and reset the decoder
    pulse(8'h00, 7, 2); pulse(8'hFF, 7, 2); pulse(8'hE0, 7, 2); pulse(8'hFF, 7, 2);
    check("t3_count", 32'(count), 32'd0);
    pulse(8'h1C, 7, 2);
    check("t3_idle", 32'(evt_data), 32'h01C);
    pop1();

    // Overflow
    for (int i = 1; i <= DEPTH + 1; i++) pulse(8'(i), 7, 1);
    check("t4_full", 32'(count), 32'(DEPTH));
    check("t4_ovf", 32'(ovf), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("t4_order", 32'(evt_data), 32'(i));
      pop1();
    end
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    do_clr();
    check("t4_ovf_clr", 32'(ovf), 32'd0);

    // Push and pop together when full, then when empty
    for (int i = 1; i <= DEPTH; i++) pulse(8'(8'h40 + i), 7, 1);
    step(1'b1, 8'h2A, 1'b1, 1'b0, 1'b1);
    check("t5_full_count", 32'(count), 32'(DEPTH));
    check("t5_no_ovf", 32'(ovf), 32'd0);
    pulse(8'h2A, 6, 1);
    for (int i = 0; i < DEPTH - 1; i++) pop1();
    check("t5_last", 32'(evt_data), 32'h02A);
    pop1();
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    check("t5_empty_pp", 32'(count), 32'd1);
    pulse(8'h33, 6, 1);
    pop1();

    // Reset discards a pending prefix; CLR beats a coincident tick
    pulse(8'hE0, 7, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pulse(8'h1C, 7, 1);
    check("t6_rst_prefix", 32'(evt_data), 32'h01C);
    pop1();
    step(1'b1, 8'h1C, 1'b0, 1'b1, 1'b1);
    pulse(8'h1C, 6, 2);
    check("t6_clr_tick", 32'(count), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sc  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : 8'($urandom);
      len = $urandom_range(1, 9);
      gap = $urandom_range(1, 4);
      for (int i = 0; i < len + gap; i++) begin
        step(i < len, sc, ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 150) == 0), ($urandom_range(0, 400) != 0));
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
